vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_lock_qual.sv | 43 ++++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator: counter width,
// default 640x480@60 timing, lock-qualification length and the colour struct.
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int RGB_W = 4;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    // PLL lock must be seen high this many consecutive clocks before timing runs
    localparam int QUAL_CNT = 16;
    localparam int QUAL_W   = 4;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_lock_qual.sv
// PLL lock qualifier: two-flop synchroniser followed by a stable counter.
// run rises after QUAL_CNT consecutive synchronised-high clocks, drops at once.
module vga_lock_qual
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic locked,
    output logic run
);

    logic              r_sync1;
    logic              r_locked_s;
    logic              r_qual;
    logic [QUAL_W-1:0] r_stable;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_qual     <= 1'b0;
            r_stable   <= '0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
            if (!r_locked_s) begin
                r_qual   <= 1'b0;
                r_stable <= '0;
            end else if (!r_qual) begin
                if (r_stable == QUAL_W'(QUAL_CNT - 1)) begin
                    r_qual <= 1'b1;
                end else begin
                    r_stable <= r_stable + 1'b1;
                end
            end
        end
    end

    // Gating with the synchronised lock makes loss of lock take effect this cycle
    assign run = r_qual & r_locked_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters, sync decode and a one-stage output register.
// Define VGA_TEST_PATTERN_EN to replace the pix_* inputs with internal colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic [RGB_W-1:0] pix_r,
    input  logic [RGB_W-1:0] pix_g,
    input  logic [RGB_W-1:0] pix_b,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de_req,
    output logic             frame_start,
    output logic [RGB_W-1:0] vga_r,
    output logic [RGB_W-1:0] vga_g,
    output logic [RGB_W-1:0] vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de
);

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             w_run;
    logic             w_hs_act;
    logic             w_vs_act;
    rgb_t             w_pix;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    rgb_t             r_rgb;
    logic             r_de;
    logic             r_hs;
    logic             r_vs;

    vga_lock_qual u_lock_qual (
        .clk    (clk),
        .rst    (rst),
        .locked (locked),
        .run    (w_run)
    );

    // Counters park at the origin whenever timing is not running
    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign de_req      = w_run && (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign x           = de_req ? r_h : '0;
    assign y           = de_req ? r_v : '0;
    assign frame_start = w_run && (r_h == '0) && (r_v == '0);
    assign w_hs_act    = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs_act    = (r_v >= VS_START) && (r_v < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_bar   = x[9:7] + {2'b00, x[6]};
        w_pix   = '0;
        w_pix.r = {RGB_W{w_bar[0]}};
        w_pix.g = {RGB_W{w_bar[1]}};
        w_pix.b = {RGB_W{w_bar[2]}};
    end
`else
    always_comb begin
        w_pix   = '0;
        w_pix.r = pix_r;
        w_pix.g = pix_g;
        w_pix.b = pix_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_de  <= 1'b0;
            r_rgb <= '0;
            r_hs  <= ~SYNC_POL;
            r_vs  <= ~SYNC_POL;
        end else begin
            r_de  <= de_req;
            r_rgb <= de_req ? w_pix : '0;
            r_hs  <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vs  <= w_vs_act ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga_r  = r_rgb.r;
    assign vga_g  = r_rgb.g;
    assign vga_b  = r_rgb.b;
    assign vga_de = r_de;
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-clock lines with a shortened 20-line frame
// so a complete frame fits in a short run; colour is checked through a scoreboard.
module tb_vga_timing_gen;

    localparam int H_TOTAL  = 800;
    localparam int V_ACT    = 12;
    localparam int V_TOTAL  = 20;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int VS_LINE  = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic [3:0] pix_r, pix_g, pix_b;
    logic [9:0] x, y;
    logic       de_req, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Upstream source answers each coordinate with its low nibble on all channels
    assign pix_r = x[3:0];
    assign pix_g = x[3:0];
    assign pix_b = x[3:0];

    vga_timing_gen #(
        .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
        .V_ACTIVE (V_ACT), .V_FP (2), .V_SYNC (2), .V_BP (4),
        .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked      (locked),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .x           (x),
        .y           (y),
        .de_req      (de_req),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de)
    );

    localparam logic [36:0] IDLE = {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 12'd0, 1'b1, 1'b1};

    function automatic logic [36:0] snap();
        return {de_req, frame_start, x, y, vga_de, vga_r, vga_g, vga_b, vga_hs, vga_vs};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (de_req !== 1'b0) begin bad++; $display("FAIL reset_de_req got=%0b want=0", de_req); end
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%0b want=0", frame_start); end
        total++;
        if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", x, y); end
        total++;
        if (vga_de !== 1'b0) begin bad++; $display("FAIL reset_vga_de got=%0b want=0", vga_de); end
        total++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            bad++; $display("FAIL reset_rgb got=%h want=000", {vga_r, vga_g, vga_b});
        end
        total++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
            bad++; $display("FAIL reset_sync got=hs%0b vs%0b want=hs1 vs1", vga_hs, vga_vs);
        end
    endtask

    // Returns the number of negedges from lock rise until frame_start, 0 on timeout
    task automatic wait_frame_start(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_lock_qual();
        int n;
        rst = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        locked = 1'b1;
        wait_frame_start(n);
        total++;
        if (n != 18) begin bad++; $display("FAIL lock_latency got=%0d want=18", n); end
    endtask

    // Entered on the frame_start cycle; leaves at h=0 of line 1
    task automatic test_line();
        int hs_first = -1;
        int hs_cnt = 0, de_cnt = 0, x_err = 0, fs_cnt = 0;
        for (int c = 0; c <= H_TOTAL; c++) begin
            if (c > 0) @(negedge clk);
            if (c < H_TOTAL && frame_start === 1'b1) fs_cnt++;
            if (c >= 1) begin
                if (vga_hs === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
                if (vga_de === 1'b1) de_cnt++;
            end
            if (c < 640 && (x !== 10'(c) || de_req !== 1'b1)) x_err++;
        end
        total++;
        if (fs_cnt != 1) begin bad++; $display("FAIL line_fs_pulses got=%0d want=1", fs_cnt); end
        total++;
        if (hs_first != 657) begin bad++; $display("FAIL line_hs_start got=%0d want=657", hs_first); end
        total++;
        if (hs_cnt != 96) begin bad++; $display("FAIL line_hs_width got=%0d want=96", hs_cnt); end
        total++;
        if (de_cnt != 640) begin bad++; $display("FAIL line_de_count got=%0d want=640", de_cnt); end
        total++;
        if (x_err != 0) begin bad++; $display("FAIL line_x_ramp got=%0d errors want=0", x_err); end
    endtask

    // Entered at h=0 of line 1; scoreboard of expected pin values one clock later
    task automatic test_colour();
        logic [12:0] exp_q[$];
        logic [12:0] e;
        logic [3:0]  hh;
        logic        m_de;
        int m_h = 0, m_v = 1;
        for (int c = 0; c <= 2 * H_TOTAL; c++) begin
            if (c > 0) @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({vga_de, vga_r, vga_g, vga_b} !== e) begin
                    bad++;
                    $display("FAIL colour c=%0d got=%h want=%h", c, {vga_de, vga_r, vga_g, vga_b}, e);
                end
            end
            m_de = (m_h < 640) && (m_v < V_ACT);
            hh = 4'(m_h);
            total++;
            if (de_req !== m_de || x !== (m_de ? 10'(m_h) : 10'd0) || y !== (m_de ? 10'(m_v) : 10'd0)) begin
                bad++;
                $display("FAIL coord c=%0d got=de%0b x%0d y%0d want=de%0b h%0d v%0d", c, de_req, x, y, m_de, m_h, m_v);
            end
            exp_q.push_back(m_de ? {1'b1, hh, hh, hh} : 13'd0);
            m_h++;
            if (m_h == H_TOTAL) begin
                m_h = 0;
                m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end
        end
    endtask

    task automatic test_frame();
        bit found = 1'b0;
        int period = -1, vs_first = -1;
        int vs_cnt = 0, de_cnt = 0, de_lines = 0;
        logic prev_de = 1'b0;
        for (int i = 0; i <= FRAME + 10; i++) begin
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL frame_wait got=timeout want=frame_start"); end
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (frame_start === 1'b1 && period < 0) period = c;
            if (vga_vs === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = c;
            end
            if (vga_de === 1'b1) de_cnt++;
            if (vga_de === 1'b1 && prev_de === 1'b0) de_lines++;
            prev_de = vga_de;
        end
        total++;
        if (period != FRAME) begin bad++; $display("FAIL frame_period got=%0d want=%0d", period, FRAME); end
        total++;
        if (vs_first != VS_LINE * H_TOTAL + 1) begin
            bad++; $display("FAIL frame_vs_start got=%0d want=%0d", vs_first, VS_LINE * H_TOTAL + 1);
        end
        total++;
        if (vs_cnt != 2 * H_TOTAL) begin bad++; $display("FAIL frame_vs_width got=%0d want=%0d", vs_cnt, 2 * H_TOTAL); end
        total++;
        if (de_lines != V_ACT) begin bad++; $display("FAIL frame_de_lines got=%0d want=%0d", de_lines, V_ACT); end
        total++;
        if (de_cnt != V_ACT * 640) begin bad++; $display("FAIL frame_de_count got=%0d want=%0d", de_cnt, V_ACT * 640); end
    endtask

    // Entered on a frame_start cycle
    task automatic test_lock_drop();
        int n;
        int idle_err = 0;
        repeat (5 * H_TOTAL + 300) @(negedge clk);
        total++;
        if (x !== 10'd300 || y !== 10'd5 || de_req !== 1'b1) begin
            bad++; $display("FAIL drop_position got=x%0d y%0d de%0b want=x300 y5 de1", x, y, de_req);
        end
        locked = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (snap() !== IDLE) begin bad++; $display("FAIL drop_idle got=%h want=%h", snap(), IDLE); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (snap() !== IDLE) idle_err++;
        end
        total++;
        if (idle_err != 0) begin bad++; $display("FAIL drop_hold got=%0d errors want=0", idle_err); end
        locked = 1'b1;
        wait_frame_start(n);
        total++;
        if (n != 18) begin bad++; $display("FAIL relock_latency got=%0d want=18", n); end
        total++;
        if (x !== 10'd0 || y !== 10'd0 || de_req !== 1'b1) begin
            bad++; $display("FAIL relock_origin got=x%0d y%0d de%0b want=x0 y0 de1", x, y, de_req);
        end
        @(negedge clk);
        total++;
        if (vga_de !== 1'b1 || x !== 10'd1) begin
            bad++; $display("FAIL relock_first got=de%0b x%0d want=de1 x1", vga_de, x);
        end
    endtask

    task automatic test_rst_midline();
        int n;
        repeat (136) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (snap() !== IDLE) begin bad++; $display("FAIL rst_midline got=%h want=%h", snap(), IDLE); end
        rst = 1'b0;
        wait_frame_start(n);
        total++;
        if (n != 18) begin bad++; $display("FAIL rst_requal got=%0d want=18", n); end
    endtask

    initial begin
        test_reset();
        test_lock_qual();
        test_line();
        test_colour();
        test_frame();
        test_lock_drop();
        test_rst_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
